// File: rtl/rx_bytes_ng.sv
// Receive byte assembler: writes frame bytes into the current RAM page,
// filters, checks CRC/overflow, hands pages over. Stats: RX_STATS_EN.
module rx_bytes_ng #(
    parameter int ADDR_W  = 8,
    parameter int N_MCAST = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           filter,
    input  logic [8*N_MCAST-1:0] mcast,
    input  logic [N_MCAST-1:0]   mcast_en,
    input  logic                 user_crc,
    input  logic                 not_drop,
    input  logic                 abort,
    input  logic                 buf_avail,
    output logic                 error,
    input  logic                 des_bus_idle,
    input  logic [7:0]           des_data,
    input  logic [15:0]          des_crc_data,
    input  logic                 des_data_clk,
    output logic                 des_force_wait_idle,
    output logic [7:0]           wr_byte,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic                 wr_clk,
    output logic [ADDR_W-1:0]    wr_flags,
    output logic                 switch,
    input  logic                 stats_clr,
    output logic [15:0]          cnt_ok,
    output logic [15:0]          cnt_err,
    output logic [15:0]          cnt_ovr
);

    localparam int CW = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;
    localparam logic [CW-1:0] PAGE = CW'(1) << ADDR_W;
    localparam logic [CW-1:0] TAIL = CW'(4);
    localparam logic [CW-1:0] TWO  = CW'(2);

    typedef enum logic [1:0] {INIT, DATA, SKIP} state_t;

    state_t            state, state_n;
    logic [CW-1:0]     byte_cnt, cnt_n, cnt_inc, last_idx;
    logic [7:0]        len, len_n;
    logic              drop, drop_n;
    logic              ovf, ovf_n;
    logic              fin, fin_n;
    logic              we, sw, err, ovr, fwi;
    logic [ADDR_W-1:0] flags_n;
    logic              mc_hit, accept, last, big, crc_ok;

    function automatic logic [ADDR_W-1:0] sat(input logic [CW-1:0] c);
        if (c >= PAGE)
            return '1;
        else
            return c[ADDR_W-1:0];
    endfunction

    assign wr_byte  = des_data;
    assign cnt_inc  = byte_cnt + CW'(1);
    assign last_idx = {{(CW-8){1'b0}}, len} + TAIL;
    assign last     = (byte_cnt == last_idx);
    assign big      = (byte_cnt >= PAGE);
    assign crc_ok   = (des_crc_data == 16'h0) || user_crc;
    assign accept   = (des_data == filter) || (des_data == 8'hff)
                   || mc_hit || (filter == 8'hff);

    // Match the destination byte against the enabled multicast entries
    always_comb begin
        mc_hit = 1'b0;
        for (int i = 0; i < N_MCAST; i++)
            if (mcast_en[i] && (mcast[8*i +: 8] == des_data))
                mc_hit = 1'b1;
    end

    // Frame state register; fin holds DATA one extra cycle after a finish
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            byte_cnt <= '0;
            len      <= '0;
            drop     <= 1'b0;
            ovf      <= 1'b0;
            fin      <= 1'b0;
        end else begin
            state    <= state_n;
            byte_cnt <= cnt_n;
            len      <= len_n;
            drop     <= drop_n;
            ovf      <= ovf_n;
            fin      <= fin_n;
        end
    end

    // Next-state, byte handling and pulse generation
    always_comb begin
        state_n = state;
        cnt_n   = byte_cnt;
        len_n   = len;
        drop_n  = drop;
        ovf_n   = ovf;
        fin_n   = fin;
        flags_n = wr_flags;
        we      = 1'b0;
        sw      = 1'b0;
        err     = 1'b0;
        ovr     = 1'b0;
        fwi     = 1'b0;
        unique case (state)
            INIT: begin
                fwi     = !des_bus_idle;
                cnt_n   = '0;
                len_n   = '0;
                drop_n  = 1'b0;
                ovf_n   = 1'b0;
                fin_n   = 1'b0;
                state_n = DATA;
            end
            DATA: begin
                priority case (1'b1)
                    fin: state_n = INIT;
                    des_bus_idle: begin
                        if (byte_cnt >= TWO && !drop) begin
                            err = 1'b1;
                            if (not_drop) begin
                                sw      = 1'b1;
                                flags_n = sat(byte_cnt);
                            end
                        end
                        if (byte_cnt != '0) begin
                            fin_n  = 1'b1;
                            drop_n = 1'b1;
                        end
                    end
                    des_data_clk: begin
                        if (byte_cnt == '0 && !buf_avail) begin
                            state_n = SKIP;
                            ovr     = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                            if (big)
                                ovf_n = 1'b1;
                            else
                                we = 1'b1;
                            if (byte_cnt == '0 && des_data == filter
                                && filter != 8'hff)
                                drop_n = 1'b1;
                            if (byte_cnt == CW'(1) && !accept)
                                drop_n = 1'b1;
                            if (byte_cnt == TWO)
                                len_n = des_data;
                            if (last) begin
                                if (!drop) begin
                                    if (crc_ok && !(ovf || big)) begin
                                        sw      = 1'b1;
                                        flags_n = '0;
                                    end else begin
                                        err = 1'b1;
                                        if (not_drop) begin
                                            sw      = 1'b1;
                                            flags_n = sat(cnt_inc);
                                        end
                                    end
                                end
                                fin_n  = 1'b1;
                                drop_n = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
            SKIP: begin
                if (des_bus_idle)
                    state_n = INIT;
            end
            default: state_n = INIT;
        endcase
        if (abort) begin
            state_n = INIT;
            we      = 1'b0;
            sw      = 1'b0;
            err     = 1'b0;
            ovr     = 1'b0;
            flags_n = wr_flags;
        end
    end

    // Registered RAM strobes and handover pulses
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error               <= 1'b0;
            switch              <= 1'b0;
            des_force_wait_idle <= 1'b0;
            wr_clk              <= 1'b0;
            wr_addr             <= '0;
            wr_flags            <= '0;
        end else begin
            error               <= err;
            switch              <= sw;
            des_force_wait_idle <= fwi;
            wr_clk              <= we;
            wr_flags            <= flags_n;
            if (we)
                wr_addr <= byte_cnt[ADDR_W-1:0];
        end
    end

`ifdef RX_STATS_EN
    // Saturating statistics; clear wins over increments
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
            cnt_ovr <= '0;
        end else if (stats_clr) begin
            cnt_ok  <= '0;
            cnt_err <= '0;
            cnt_ovr <= '0;
        end else begin
            if (sw && flags_n == '0 && cnt_ok != 16'hffff)
                cnt_ok <= cnt_ok + 16'd1;
            if (err && cnt_err != 16'hffff)
                cnt_err <= cnt_err + 16'd1;
            if (ovr && cnt_ovr != 16'hffff)
                cnt_ovr <= cnt_ovr + 16'd1;
        end
    end
`else
    logic unused_stats;
    assign unused_stats = stats_clr | ovr;
    assign cnt_ok  = '0;
    assign cnt_err = '0;
    assign cnt_ovr = '0;
`endif

endmodule

// File: tb/tb_rx_bytes_ng.sv
// Directed bench for rx_bytes_ng: ADDR_W=8 instance plus an
// ADDR_W=6 instance sharing stimulus for the page overflow case.
module tb_rx_bytes_ng;

`ifdef RX_STATS_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic        clk = 0;
    logic        reset = 1;
    logic [7:0]  filter = 8'h05;
    logic [15:0] mcast = {8'h40, 8'h30};
    logic [1:0]  mcast_en = 2'b11;
    logic        user_crc = 0, not_drop = 0, abort = 0;
    logic        buf_avail = 1, des_bus_idle = 1;
    logic [7:0]  des_data = 0;
    logic [15:0] des_crc_data = 0;
    logic        des_data_clk = 0, stats_clr = 0;

    logic        error, fwi, wr_clk, switch;
    logic [7:0]  wr_byte, wr_addr, wr_flags;
    logic [15:0] cnt_ok, cnt_err, cnt_ovr;

    logic        error6, fwi6, wr_clk6, switch6;
    logic [7:0]  wr_byte6;
    logic [5:0]  wr_addr6, wr_flags6;
    logic [15:0] cnt_ok6, cnt_err6, cnt_ovr6;

    rx_bytes_ng #(.ADDR_W(8), .N_MCAST(2)) dut (
        .clk(clk), .reset(reset), .filter(filter), .mcast(mcast),
        .mcast_en(mcast_en), .user_crc(user_crc), .not_drop(not_drop),
        .abort(abort), .buf_avail(buf_avail), .error(error),
        .des_bus_idle(des_bus_idle), .des_data(des_data),
        .des_crc_data(des_crc_data), .des_data_clk(des_data_clk),
        .des_force_wait_idle(fwi), .wr_byte(wr_byte),
        .wr_addr(wr_addr), .wr_clk(wr_clk), .wr_flags(wr_flags),
        .switch(switch), .stats_clr(stats_clr), .cnt_ok(cnt_ok),
        .cnt_err(cnt_err), .cnt_ovr(cnt_ovr)
    );

    rx_bytes_ng #(.ADDR_W(6), .N_MCAST(2)) dut6 (
        .clk(clk), .reset(reset), .filter(filter), .mcast(mcast),
        .mcast_en(mcast_en), .user_crc(user_crc), .not_drop(not_drop),
        .abort(abort), .buf_avail(buf_avail), .error(error6),
        .des_bus_idle(des_bus_idle), .des_data(des_data),
        .des_crc_data(des_crc_data), .des_data_clk(des_data_clk),
        .des_force_wait_idle(fwi6), .wr_byte(wr_byte6),
        .wr_addr(wr_addr6), .wr_clk(wr_clk6), .wr_flags(wr_flags6),
        .switch(switch6), .stats_clr(stats_clr), .cnt_ok(cnt_ok6),
        .cnt_err(cnt_err6), .cnt_ovr(cnt_ovr6)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int tot_wr = 0, tot_sw = 0, tot_err = 0, tot_fwi = 0;
    int tot_wr6 = 0, tot_sw6 = 0, tot_err6 = 0;
    logic [7:0] sw_flags = 0;
    logic [5:0] sw_flags6 = 0;
    logic [7:0] addr_log [0:2047];

    int d_wr, d_sw, d_err, d_fwi, d_wr6, d_sw6, d_err6, addr_bad;
    logic sw_last, err_last;
    logic [1:0] st0, st1, st2;
    logic [7:0] fb [0:127];
    int flen;

    // Observe DUT outputs away from the active edge
    always @(negedge clk) begin
        if (wr_clk) begin
            if (tot_wr < 2048) addr_log[tot_wr] = wr_addr;
            tot_wr++;
        end
        if (switch) begin tot_sw++; sw_flags = wr_flags; end
        if (error) tot_err++;
        if (fwi) tot_fwi++;
        if (wr_clk6) tot_wr6++;
        if (switch6) begin tot_sw6++; sw_flags6 = wr_flags6; end
        if (error6) tot_err6++;
    end

    task automatic build(input logic [7:0] src, input logic [7:0] dst,
                         input logic [7:0] len);
        fb[0] = src;
        fb[1] = dst;
        fb[2] = len;
        for (int i = 0; i < int'(len); i++) fb[3+i] = 8'hAA + 8'(i);
        fb[3+int'(len)] = 8'h12;
        fb[4+int'(len)] = 8'h34;
        flen = int'(len) + 5;
    endtask

    task automatic send(input int n, input bit ab);
        int w0, s0, e0, f0, w6, s6, e6;
        w0 = tot_wr; s0 = tot_sw; e0 = tot_err; f0 = tot_fwi;
        w6 = tot_wr6; s6 = tot_sw6; e6 = tot_err6;
        des_bus_idle = 0;
        repeat (2) @(posedge clk);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            des_data = fb[i];
            des_data_clk = 1;
            if (ab && i == n - 1) abort = 1;
            @(posedge clk); #1;
            des_data_clk = 0;
            abort = 0;
            if (i == n - 1) begin
                sw_last = switch;
                err_last = error;
                st0 = dut.state;
                @(posedge clk); #1 st1 = dut.state;
                @(posedge clk); #1 st2 = dut.state;
            end
        end
        @(posedge clk); #1;
        des_bus_idle = 1;
        repeat (6) @(posedge clk);
        #1;
        d_wr = tot_wr - w0; d_sw = tot_sw - s0;
        d_err = tot_err - e0; d_fwi = tot_fwi - f0;
        d_wr6 = tot_wr6 - w6; d_sw6 = tot_sw6 - s6;
        d_err6 = tot_err6 - e6;
        addr_bad = 0;
        for (int k = 0; k < d_wr && w0 + k < 2048; k++)
            if (addr_log[w0+k] !== 8'(k)) addr_bad++;
    endtask

    task automatic clr_stats();
        @(posedge clk); #1 stats_clr = 1;
        @(posedge clk); #1 stats_clr = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({error, switch, wr_clk, fwi} !== 4'b0) begin
            errors++;
            $display("FAIL rst_pulses got %b exp 0000",
                     {error, switch, wr_clk, fwi});
        end
        checks++;
        if ({wr_addr, wr_flags} !== 16'h0) begin
            errors++;
            $display("FAIL rst_addr_flags got %h exp 0000",
                     {wr_addr, wr_flags});
        end
        checks++;
        if ({cnt_ok, cnt_err, cnt_ovr} !== 48'h0) begin
            errors++;
            $display("FAIL rst_cnt got %h exp 0",
                     {cnt_ok, cnt_err, cnt_ovr});
        end
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_good();
        clr_stats();
        build(8'h01, 8'h05, 8'h02);
        send(flen, 0);
        checks++;
        if (d_wr !== 7) begin
            errors++; $display("FAIL good_wr got %0d exp 7", d_wr);
        end
        checks++;
        if (addr_bad !== 0) begin
            errors++; $display("FAIL good_addr got %0d bad exp 0", addr_bad);
        end
        checks++;
        if (sw_last !== 1'b1 || err_last !== 1'b0) begin
            errors++;
            $display("FAIL good_timing got sw=%b err=%b exp sw=1 err=0",
                     sw_last, err_last);
        end
        checks++;
        if (d_sw !== 1 || d_err !== 0 || sw_flags !== 8'h0) begin
            errors++;
            $display("FAIL good_sw got sw=%0d err=%0d fl=%h exp 1 0 00",
                     d_sw, d_err, sw_flags);
        end
        checks++;
        if (st1 !== 2'd0 || st2 !== 2'd1) begin
            errors++;
            $display("FAIL good_state got %0d,%0d exp 0,1", st1, st2);
        end
        checks++;
        if (d_fwi !== 1) begin
            errors++; $display("FAIL good_fwi got %0d exp 1", d_fwi);
        end
        checks++;
        if (wr_byte !== 8'h34) begin
            errors++; $display("FAIL wr_byte got %h exp 34", wr_byte);
        end
        checks++;
        if (cnt_ok !== 16'(S)) begin
            errors++; $display("FAIL cnt_ok got %0d exp %0d", cnt_ok, S);
        end
    endtask

    task automatic test_crc_err();
        clr_stats();
        build(8'h01, 8'h05, 8'h02);
        des_crc_data = 16'h1234;
        not_drop = 1;
        send(flen, 0);
        checks++;
        if (d_err !== 1 || d_sw !== 1 || sw_flags !== 8'h07) begin
            errors++;
            $display("FAIL crc_nd got err=%0d sw=%0d fl=%h exp 1 1 07",
                     d_err, d_sw, sw_flags);
        end
        checks++;
        if (cnt_err !== 16'(S) || cnt_ok !== 16'h0) begin
            errors++;
            $display("FAIL crc_cnt got err=%0d ok=%0d exp %0d 0",
                     cnt_err, cnt_ok, S);
        end
        not_drop = 0;
        send(flen, 0);
        checks++;
        if (d_err !== 1 || d_sw !== 0) begin
            errors++;
            $display("FAIL crc_drop got err=%0d sw=%0d exp 1 0", d_err, d_sw);
        end
        des_crc_data = 16'h0;
    endtask

    task automatic test_filter();
        build(8'h01, 8'h40, 8'h02);
        send(flen, 0);
        checks++;
        if (d_sw !== 1 || sw_flags !== 8'h0) begin
            errors++;
            $display("FAIL mcast_hit got sw=%0d fl=%h exp 1 00", d_sw, sw_flags);
        end
        mcast_en = 2'b01;
        send(flen, 0);
        checks++;
        if (d_sw !== 0 || d_err !== 0) begin
            errors++;
            $display("FAIL mcast_off got sw=%0d err=%0d exp 0 0", d_sw, d_err);
        end
        filter = 8'hff;
        send(flen, 0);
        checks++;
        if (d_sw !== 1) begin
            errors++; $display("FAIL promisc got sw=%0d exp 1", d_sw);
        end
        filter = 8'h05;
        mcast_en = 2'b11;
        build(8'h01, 8'hff, 8'h02);
        send(flen, 0);
        checks++;
        if (d_sw !== 1) begin
            errors++; $display("FAIL bcast got sw=%0d exp 1", d_sw);
        end
        build(8'h05, 8'h05, 8'h02);
        send(flen, 0);
        checks++;
        if (d_sw !== 0 || d_err !== 0 || d_wr !== 7) begin
            errors++;
            $display("FAIL own_src got sw=%0d err=%0d wr=%0d exp 0 0 7",
                     d_sw, d_err, d_wr);
        end
    endtask

    task automatic test_overflow();
        build(8'h01, 8'h05, 8'd70);
        not_drop = 1;
        send(flen, 0);
        checks++;
        if (d_wr6 !== 64 || d_err6 !== 1 || d_sw6 !== 1) begin
            errors++;
            $display("FAIL ovf6 got wr=%0d err=%0d sw=%0d exp 64 1 1",
                     d_wr6, d_err6, d_sw6);
        end
        checks++;
        if (sw_flags6 !== 6'h3f) begin
            errors++; $display("FAIL ovf6_flags got %h exp 3f", sw_flags6);
        end
        checks++;
        if (d_wr !== 75 || d_sw !== 1 || sw_flags !== 8'h0 || d_err !== 0) begin
            errors++;
            $display("FAIL long8 got wr=%0d sw=%0d fl=%h err=%0d exp 75 1 00 0",
                     d_wr, d_sw, sw_flags, d_err);
        end
        not_drop = 0;
        send(flen, 0);
        checks++;
        if (d_sw6 !== 0 || d_err6 !== 1) begin
            errors++;
            $display("FAIL ovf6_drop got sw=%0d err=%0d exp 0 1", d_sw6, d_err6);
        end
    endtask

    task automatic test_no_buf();
        clr_stats();
        build(8'h01, 8'h05, 8'h02);
        buf_avail = 0;
        send(flen, 0);
        buf_avail = 1;
        checks++;
        if (d_wr !== 0 || d_sw !== 0 || d_err !== 0) begin
            errors++;
            $display("FAIL nobuf got wr=%0d sw=%0d err=%0d exp 0 0 0",
                     d_wr, d_sw, d_err);
        end
        checks++;
        if (cnt_ovr !== 16'(S)) begin
            errors++; $display("FAIL cnt_ovr got %0d exp %0d", cnt_ovr, S);
        end
        send(flen, 0);
        checks++;
        if (d_wr !== 7 || d_sw !== 1 || sw_flags !== 8'h0) begin
            errors++;
            $display("FAIL after_nobuf got wr=%0d sw=%0d fl=%h exp 7 1 00",
                     d_wr, d_sw, sw_flags);
        end
    endtask

    task automatic test_idle_abort();
        build(8'h01, 8'h05, 8'h02);
        not_drop = 1;
        send(1, 0);
        checks++;
        if (d_sw !== 0 || d_err !== 0) begin
            errors++;
            $display("FAIL idle1 got sw=%0d err=%0d exp 0 0", d_sw, d_err);
        end
        clr_stats();
        send(flen, 1);
        checks++;
        if (d_sw !== 0 || d_err !== 0 || st0 !== 2'd0) begin
            errors++;
            $display("FAIL abort got sw=%0d err=%0d st=%0d exp 0 0 0",
                     d_sw, d_err, st0);
        end
        checks++;
        if (cnt_ok !== 16'h0 || cnt_err !== 16'h0) begin
            errors++;
            $display("FAIL abort_cnt got ok=%0d err=%0d exp 0 0",
                     cnt_ok, cnt_err);
        end
        send(4, 0);
        checks++;
        if (d_err !== 1 || d_sw !== 1 || sw_flags !== 8'h04) begin
            errors++;
            $display("FAIL idle4 got err=%0d sw=%0d fl=%h exp 1 1 04",
                     d_err, d_sw, sw_flags);
        end
        not_drop = 0;
    endtask

    task automatic test_reset_mid();
        int s0;
        s0 = tot_sw;
        des_bus_idle = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            des_data = fb[i];
            des_data_clk = 1;
            @(posedge clk); #1;
            des_data_clk = 0;
        end
        reset = 1;
        #1;
        checks++;
        if ({wr_clk, switch, error, wr_addr, wr_flags} !== 19'h0) begin
            errors++;
            $display("FAIL mid_rst got clk=%b addr=%h fl=%h exp 0 00 00",
                     wr_clk, wr_addr, wr_flags);
        end
        des_bus_idle = 1;
        repeat (3) @(posedge clk);
        #1 reset = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (tot_sw - s0 !== 0) begin
            errors++; $display("FAIL mid_rst_sw got %0d exp 0", tot_sw - s0);
        end
        send(flen, 0);
        checks++;
        if (d_sw !== 1 || d_wr !== 7) begin
            errors++;
            $display("FAIL post_rst got sw=%0d wr=%0d exp 1 7", d_sw, d_wr);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_crc_err();
        test_filter();
        test_overflow();
        test_no_buf();
        test_idle_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_bytes_ng.md
# rx_bytes_ng

Next-generation receive byte assembler. It sits between the rx deserializer and the ping-pong receive RAM, and writes each frame byte into the current page. It applies address filtering against one unicast address plus N_MCAST configurable multicast addresses, checks the CRC residue, detects buffer overflow and missing-buffer overrun, and hands the completed page over with a one-cycle switch pulse.

## Interface
- ADDR_W, 8, RAM page address width; page holds 2^ADDR_W bytes (legal 6..12).
- N_MCAST, 2, number of multicast filter entries (legal 1..8).
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- filter  in  8  own address; 8'hff means promiscuous.
- mcast  in  8*N_MCAST  multicast addresses; entry i is bits [8i+7:8i].
- mcast_en  in  N_MCAST  per-entry enable.
- user_crc  in  1  ignore the CRC result.
- not_drop  in  1  hand over errored frames instead of discarding them.
- abort  in  1  abandon the current frame.
- buf_avail  in  1  pp_ram has a free page.
- error  out  1  pulse: CRC error, incomplete frame or overflow.
- des_bus_idle  in  1; des_data  in  8; des_crc_data  in  16 (residue, 0 = good); des_data_clk  in  1 (byte strobe).
- des_force_wait_idle  out  1  pulse: deserializer discards input until the bus is idle.
- wr_byte  out  8  equals des_data (combinational).
- wr_addr  out  ADDR_W; wr_clk  out  1; wr_flags  out  ADDR_W; switch  out  1.
- stats_clr  in  1; cnt_ok, cnt_err, cnt_ovr  out  16 each (see Configuration).

## Operation
- Frame format: src, dst, len, len data bytes, crc_l, crc_h. Total length is len+5 bytes.
- byte_cnt is max(9, ADDR_W+1) bits wide. Last byte when byte_cnt == len+4 (zero-extended add). "Count" = bytes received.
- FSM states INIT, DATA, SKIP:
  - INIT: lasts 1 cycle. If !des_bus_idle, pulse des_force_wait_idle. Clear byte_cnt, len and drop. Go to DATA.
  - DATA, strobe with byte_cnt==0: if !buf_avail, go to SKIP with no write and cnt_ovr++. Otherwise, if des_data==filter and filter!=8'hff, set drop.
  - DATA, strobe with byte_cnt==1: accept if des_data==filter, ==8'hff, equals any enabled mcast entry, or filter==8'hff. Otherwise set drop.
  - DATA, strobe with byte_cnt==2: latch len.
  - DATA, write rule: every strobe in DATA with byte_cnt < 2^ADDR_W (and not the SKIP case) gives wr_addr=byte_cnt and a wr_clk pulse. Later bytes set ovf and are not written.
  - DATA, last byte, not dropped:
    - CRC good (residue 0 or user_crc) and !ovf: wr_flags=0, switch.
    - Otherwise: error. If not_drop, also wr_flags=count and switch.
    - In every case, finish and return to INIT.
  - DATA, des_bus_idle with byte_cnt>=2 and !drop: error. If not_drop, wr_flags=count and switch. Then finish.
  - DATA, des_bus_idle with byte_cnt==1: finish silently.
  - DATA, des_bus_idle with byte_cnt==0: stay in DATA.
  - SKIP: ignore strobes. On des_bus_idle, go to INIT.
- Precedence: des_bus_idle is evaluated before des_data_clk in the same cycle.
- wr_flags count saturates to all-ones when count ≥ 2^ADDR_W. wr_flags holds its value between switches.
- After any finish, drop is set until INIT, so there is never a second switch.
- Abort: the next state is INIT. In the abort cycle error and switch are suppressed and no counter increments. Abort outranks last-byte completion in the same cycle.

## Timing
- Reset values: error=0, des_force_wait_idle=0, wr_addr=0, wr_clk=0, wr_flags=0, switch=0, counters=0, state=INIT.
- wr_clk and wr_addr are registered: they appear 1 cycle after the strobe. des_data is held by the deserializer until the next strobe.
- switch and error are 1-cycle pulses, 1 cycle after the last-byte strobe or the idle detection.
- State is INIT 2 cycles after the last-byte strobe and DATA 3 cycles after it.
- Reset asserted mid-frame: all outputs return to their reset values immediately, with no switch.

## Configuration
- RX_STATS_EN defined:
  - cnt_ok counts switches with wr_flags==0.
  - cnt_err counts error pulses.
  - cnt_ovr counts SKIP entries.
  - All counters are 16-bit and saturate at 16'hffff.
  - stats_clr is a synchronous clear and has priority over increments.
- RX_STATS_EN undefined: no counter flops. cnt_* are tied to 0, stats_clr is ignored, and ports are unchanged.

## Test plan
- filter=8'h05, frame 01,05,02,AA,BB plus good CRC: wr_clk ×7 at addresses 0..6; switch with wr_flags=0; error=0; cnt_ok=1.
- Same frame with crc_l corrupted, not_drop=1: error and switch with wr_flags=7; cnt_err=1. Repeat with not_drop=0: error pulse only, no switch.
- dst=8'h40, mcast entry 1=8'h40: frame accepted. Clear mcast_en[1]: no switch, no error. Then set filter=8'hff: frame accepted.
- ADDR_W=6, len=70 (75 bytes), good CRC, not_drop=1: 64 writes; error; wr_flags=6'h3f. With not_drop=0: no switch.
- buf_avail=0 at byte 0: no wr_clk, no switch, no error; cnt_ovr=1. Next frame received normally after idle.
- Idle after 4 bytes: error and switch with wr_flags=4 (not_drop=1). Abort coincident with the last byte: no switch, no error; FSM in INIT on the next cycle.
